writeback_arbiter: RTL

Producer side of the register-file write port: merges ALU results and memory load responses into the single `regWrite`/`writeRegister`/`writeData` channel consumed by the 32×32 register file. Load responses are buffered in a small in-order FIFO, sign/zero-extended per RISC-V load type, and arbitrated against the ALU path with a starvation guard. A pending-destination mask is exported for hazard detection.

---
 rtl/writeback_if.sv | 41 ++++
 rtl/writeback_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_if.sv
// Register-file write-port producer bundle: ALU result channel, load
// response channel, and the single write channel toward the register file.
interface writeback_if;
    // ALU result channel
    logic        aluValid;
    logic        aluReady;
    logic [4:0]  aluRd;
    logic [31:0] aluData;

    // Load response channel
    logic        loadValid;
    logic        loadReady;
    logic [4:0]  loadRd;
    logic [31:0] loadData;
    logic [2:0]  loadFunct3;
    logic [1:0]  loadOffset;

    // Register-file write channel and hazard mask
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [31:0] pendingMask;

    // Producer of ALU results / load responses, consumer of the write port
    modport master (
        output aluValid, aluRd, aluData,
        input  aluReady,
        output loadValid, loadRd, loadData, loadFunct3, loadOffset,
        input  loadReady,
        input  regWrite, writeRegister, writeData, pendingMask
    );

    // The arbiter itself
    modport slave (
        input  aluValid, aluRd, aluData,
        output aluReady,
        input  loadValid, loadRd, loadData, loadFunct3, loadOffset,
        output loadReady,
        output regWrite, writeRegister, writeData, pendingMask
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results and buffered load responses onto the register-file
// write port. Loads sit in a small in-order FIFO, are extended on the way
// out, and are forced through after STARVE_LIMIT lost arbitration cycles.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    writeback_if.slave wb
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    // Load type extension: byte lane picked by the full offset, halfword
    // lane by offset[1]; unknown codes pass the word through unchanged.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  offset
    );
        logic [31:0]        shifted;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        logic signed [31:0] res;
        shifted = word >> {offset, 3'b000};
        lane_b  = signed'(shifted[7:0]);
        lane_h  = signed'(offset[1] ? word[31:16] : word[15:0]);
        case (funct3)
            3'b000:  res = {{24{lane_b[7]}}, lane_b};
            3'b100:  res = {24'd0, lane_b};
            3'b001:  res = {{16{lane_h[15]}}, lane_h};
            3'b101:  res = {16'd0, lane_h};
            default: res = signed'(word);
        endcase
        return res;
    endfunction

    // FIFO payload (data path, not reset)
    logic [4:0]  fifo_rd     [DEPTH];
    logic [31:0] fifo_data   [DEPTH];
    logic [2:0]  fifo_funct3 [DEPTH];
    logic [1:0]  fifo_offset [DEPTH];

    // FIFO and arbitration control
    logic [DEPTH-1:0] ent_vld;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve;

    logic fifo_nonempty;
    logic starved;
    logic push;
    logic alu_take;
    logic pop;

    // FIFO head as seen this cycle
    logic [4:0]  head_rd_p0;
    logic [31:0] head_data_p0;
    logic [2:0]  head_funct3_p0;
    logic [1:0]  head_offset_p0;

    // Registered write port
    logic        wr_vld_p1;
    logic [4:0]  wr_rd_p1;
    logic [31:0] wr_data_p1;

    logic [31:0] pend_mask;

    assign fifo_nonempty = (count != '0);
    assign starved       = fifo_nonempty && (starve == STARVE_MAX);

    assign wb.aluReady   = !starved;
    assign wb.loadReady  = (count < DEPTH_CNT);

    assign push     = wb.loadValid && wb.loadReady;
    assign alu_take = wb.aluValid && !starved;
    // Forced pop falls out naturally: a starved FIFO blocks the ALU path.
    assign pop      = fifo_nonempty && !alu_take;

    assign head_rd_p0     = fifo_rd[rd_ptr];
    assign head_data_p0   = fifo_data[rd_ptr];
    assign head_funct3_p0 = fifo_funct3[rd_ptr];
    assign head_offset_p0 = fifo_offset[rd_ptr];

    // Capture an accepted load response into the tail slot
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]     <= wb.loadRd;
            fifo_data[wr_ptr]   <= wb.loadData;
            fifo_funct3[wr_ptr] <= wb.loadFunct3;
            fifo_offset[wr_ptr] <= wb.loadOffset;
        end
    end

    // Pointer, occupancy and per-entry valid bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                ent_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Count cycles the head has waited; saturates so the forced pop holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (!fifo_nonempty || pop) begin
            starve <= '0;
        end else if (starve != STARVE_MAX) begin
            starve <= starve + STV_W'(1);
        end
    end

    // ---- stage p0 -> p1: selected source into the write-port register ----
    // Writes to x0 are swallowed here; destination/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_p1  <= 1'b0;
            wr_rd_p1   <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= 1'b0;
            if (alu_take) begin
                if (wb.aluRd != 5'd0) begin
                    wr_vld_p1  <= 1'b1;
                    wr_rd_p1   <= wb.aluRd;
                    wr_data_p1 <= wb.aluData;
                end
            end else if (pop) begin
                if (head_rd_p0 != 5'd0) begin
                    wr_vld_p1  <= 1'b1;
                    wr_rd_p1   <= head_rd_p0;
                    wr_data_p1 <= extend_load(head_data_p0, head_funct3_p0,
                                              head_offset_p0);
                end
            end
        end
    end

    // Destinations still owed by the FIFO, for the hazard unit
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                pend_mask[fifo_rd[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    assign wb.regWrite      = wr_vld_p1;
    assign wb.writeRegister = wr_rd_p1;
    assign wb.writeData     = wr_data_p1;
    assign wb.pendingMask   = pend_mask;

endmodule
